// File: rtl/ctrl_subrutinas.sv
// ctrl_subrutinas: call/ret/interrupt sequencer driving the return-address stack.
// Tracks its own stack depth so illegal push/pop never reach the stack.
module ctrl_subrutinas #(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 16,
  parameter int NUM_IRQ = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE = 10'h3F0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_actual,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic              is_reti,
  input  logic              is_ei,
  input  logic              is_di,
  input  logic [ADDR_W-1:0] call_dest,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [ADDR_W-1:0] pila_out,
  input  logic              pila_underflow,
  input  logic              pila_overflow,
  output logic              push,
  output logic              pop,
  output logic              interrupt,
  output logic [ADDR_W-1:0] pila_pc,
  output logic [1:0]        pc_sel,
  output logic [ADDR_W-1:0] pc_dest,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic              ie,
  output logic              halt,
  output logic [1:0]        err_code
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);
  typedef enum logic [1:0] {RUN, ISR, FALLO} state_t;
  state_t state, state_n;
  logic [DW-1:0] depth, depth_n;
  logic [NUM_IRQ-1:0] pending, irq_q;
  logic [IW-1:0] idx;
  logic [1:0] err_n;
  logic ie_n, take;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      depth <= '0;
      pending <= '0;
      irq_q <= '0;
      ie <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state <= state_n;
      depth <= depth_n;
      pending <= (pending & ~irq_ack) | (irq & ~irq_q);
      irq_q <= irq;
      ie <= ie_n;
      err_code <= err_n;
    end
  // lowest index wins
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pending[i]) idx = IW'(i);
  end
  assign take = ie && |pending && state == RUN && depth < DMAX;
  assign halt = state == FALLO;
  // outputs are gated by reset so an in-flight strobe drops the instant reset asserts
  always_comb begin
    push = 1'b0;
    pop = 1'b0;
    interrupt = 1'b0;
    pila_pc = '0;
    pc_sel = 2'b00;
    pc_dest = '0;
    irq_ack = '0;
    state_n = state;
    depth_n = depth;
    ie_n = ie;
    err_n = err_code;
    if (reset && state != FALLO) begin
      if (take) begin
        push = 1'b1;
        pila_pc = pc_actual;
        pc_sel = 2'b11;
        pc_dest = VEC_BASE + ADDR_W'(idx);
        irq_ack = NUM_IRQ'(1) << idx;
        ie_n = 1'b0;
        state_n = ISR;
        depth_n = depth + 1'b1;
      end else if (is_call) begin
        if (depth == DMAX) begin
          state_n = FALLO;
          err_n = 2'b01;
        end else begin
          push = 1'b1;
          pila_pc = pc_actual;
          pc_sel = 2'b01;
          pc_dest = call_dest;
          depth_n = depth + 1'b1;
        end
      end else if (is_ret) begin
        if (depth == '0) begin
          state_n = FALLO;
          err_n = 2'b10;
        end else begin
          pop = 1'b1;
          pc_sel = 2'b10;
          pc_dest = pila_out;
          depth_n = depth - 1'b1;
        end
      end else if (is_reti) begin
        if (state == ISR && depth != '0) begin
          pop = 1'b1;
          interrupt = 1'b1;
          pc_sel = 2'b10;
          pc_dest = pila_out;
          ie_n = 1'b1;
          state_n = RUN;
          depth_n = depth - 1'b1;
        end else begin
          state_n = FALLO;
          err_n = 2'b10;
        end
      end else if (is_ei || is_di) ie_n = !is_di;
      if (pila_overflow || pila_underflow) begin
        state_n = FALLO;
        err_n = 2'b11;
      end
    end
  end
endmodule

// File: tb/tb_ctrl_subrutinas.sv
// tb_ctrl_subrutinas: directed checks of call/ret, interrupts, depth faults and reset.
module tb_ctrl_subrutinas;
  logic clk = 1'b0, reset;
  logic [9:0] pc, call_dest, pila_out, pila_pc, pc_dest;
  logic is_call, is_ret, is_reti, is_ei, is_di, pila_uf, pila_of;
  logic [3:0] irq, irq_ack;
  logic push, pop, intr, ie, halt;
  logic [1:0] pc_sel, err_code;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ctrl_subrutinas dut (
    .clk(clk), .reset(reset), .pc_actual(pc), .is_call(is_call), .is_ret(is_ret),
    .is_reti(is_reti), .is_ei(is_ei), .is_di(is_di), .call_dest(call_dest), .irq(irq),
    .pila_out(pila_out), .pila_underflow(pila_uf), .pila_overflow(pila_of),
    .push(push), .pop(pop), .interrupt(intr), .pila_pc(pila_pc), .pc_sel(pc_sel),
    .pc_dest(pc_dest), .irq_ack(irq_ack), .ie(ie), .halt(halt), .err_code(err_code)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    pc = '0; call_dest = '0; pila_out = '0;
    is_call = 0; is_ret = 0; is_reti = 0; is_ei = 0; is_di = 0;
    pila_uf = 0; pila_of = 0; irq = '0;
  endtask
  initial begin
    reset = 0;
    step();
    step(); #1;
    chk("rst_push", push, 0); chk("rst_pop", pop, 0); chk("rst_sel", pc_sel, 0);
    chk("rst_pila_pc", pila_pc, 0); chk("rst_dest", pc_dest, 0); chk("rst_halt", halt, 0);
    chk("rst_ie", ie, 0); chk("rst_err", err_code, 0); chk("rst_ack", irq_ack, 0);
    @(negedge clk) reset = 1;
    step(); pc = 10'h010; call_dest = 10'h080; is_call = 1; #1;
    chk("call_push", push, 1); chk("call_pc", pila_pc, 10'h010); chk("call_sel", pc_sel, 1);
    step(); pc = 10'h081; is_ret = 1; pila_out = 10'h011; #1;
    chk("ret_pop", pop, 1); chk("ret_int", intr, 0); chk("ret_sel", pc_sel, 2);
    chk("ret_dest", pc_dest, 10'h011); chk("ret_push", push, 0);
    step(); is_ei = 1;
    step(); pc = 10'h020; irq = 4'b0100; #1;
    chk("ei_ie", ie, 1); chk("edge_noack", irq_ack, 0);
    step(); pc = 10'h020; #1;
    chk("irq2_push", push, 1); chk("irq2_pc", pila_pc, 10'h020); chk("irq2_sel", pc_sel, 3);
    chk("irq2_dest", pc_dest, 10'h3F2); chk("irq2_ack", irq_ack, 4'b0100);
    step(); #1;
    chk("isr_ie", ie, 0); chk("isr_ack", irq_ack, 0);
    step(); is_reti = 1; pila_out = 10'h020; #1;
    chk("reti_pop", pop, 1); chk("reti_int", intr, 1); chk("reti_dest", pc_dest, 10'h020);
    chk("reti_sel", pc_sel, 2);
    step(); #1;
    chk("reti_ie", ie, 1); chk("reti_halt", halt, 0);
    step(); irq = 4'b1010; #1;
    chk("two_noack", irq_ack, 0);
    step(); irq = 4'b1010; pc = 10'h030; #1;
    chk("irq1_ack", irq_ack, 4'b0010); chk("irq1_dest", pc_dest, 10'h3F1);
    step(); irq = 4'b1010; is_reti = 1; pila_out = 10'h030; #1;
    chk("reti1_pop", pop, 1); chk("reti1_noack", irq_ack, 0);
    step(); irq = 4'b1010; pc = 10'h030; #1;
    chk("irq3_ack", irq_ack, 4'b1000); chk("irq3_dest", pc_dest, 10'h3F3);
    chk("irq3_push", push, 1);
    step(); irq = 4'b1010; is_reti = 1; pila_out = 10'h030; #1;
    chk("reti3_pop", pop, 1);
    step(); #1;
    chk("empty_ack", irq_ack, 0); chk("back_ie", ie, 1);
    step(); is_di = 1; is_ei = 1;
    step(); #1;
    chk("di_wins", ie, 0);
    for (int i = 0; i < 16; i++) begin
      step(); pc = 10'(i + 16'h100); call_dest = 10'h200; is_call = 1; #1;
      chk("nest_push", push, 1);
    end
    step(); pc = 10'h1FF; is_call = 1; #1;
    chk("ovf_nopush", push, 0); chk("ovf_prehalt", halt, 0);
    step(); #1;
    chk("ovf_halt", halt, 1); chk("ovf_err", err_code, 1);
    step(); is_ret = 1; is_ei = 1; irq = 4'b0001; pila_out = 10'h055; #1;
    chk("fallo_pop", pop, 0); chk("fallo_sel", pc_sel, 0); chk("fallo_ack", irq_ack, 0);
    step(); #1;
    chk("fallo_sticky", halt, 1); chk("fallo_ie", ie, 0); chk("fallo_err", err_code, 1);
    reset = 0;
    step(); reset = 1;
    step(); is_ret = 1; pila_out = 10'h123; #1;
    chk("unf_pop", pop, 0); chk("unf_sel", pc_sel, 0);
    step(); #1;
    chk("unf_halt", halt, 1); chk("unf_err", err_code, 2);
    reset = 0;
    step(); reset = 1;
    step(); is_reti = 1; #1;
    chk("reti_run_pop", pop, 0);
    step(); #1;
    chk("reti_run_halt", halt, 1); chk("reti_run_err", err_code, 2);
    reset = 0;
    step(); reset = 1;
    step(); pila_of = 1; #1;
    chk("flag_prehalt", halt, 0);
    step(); #1;
    chk("flag_halt", halt, 1); chk("flag_err", err_code, 3);
    reset = 0;
    step(); reset = 1;
    step(); irq = 4'b0001;
    step(); pc = 10'h055; is_call = 1; #1;
    chk("pre_rst_push", push, 1);
    #2 reset = 0; #1;
    chk("async_push", push, 0); chk("async_pc", pila_pc, 0); chk("async_sel", pc_sel, 0);
    step(); reset = 1;
    step(); is_ei = 1; #1;
    chk("post_halt", halt, 0); chk("post_ie", ie, 0);
    step(); #1;
    chk("post_ie1", ie, 1); chk("post_pending", irq_ack, 0);
    step(); is_ret = 1; #1;
    chk("post_depth0", pop, 0);
    step(); #1;
    chk("post_unf", err_code, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ctrl_subrutinas.md
Name: ctrl_subrutinas

Overview:
- Control-flow sequencer that initiates every transaction on the return-address stack (`pila`).
- Decodes call/ret/reti/ei/di strobes from the instruction decoder and latches external interrupt requests.
- Drives the stack's push/pop/interrupt/pc_addr inputs and consumes its return-address output and error flags.
- Produces the PC-select and target address for the single-cycle datapath. Keeps its own depth count so that illegal stack operations are blocked before they reach the stack.

Parameters:
- ADDR_W, 10, PC/address width.
- DEPTH, 16, stack capacity; must match `pila` (16 entries).
- NUM_IRQ, 4, number of interrupt request lines.
- VEC_BASE, 10'h3F0, vector for IRQ i = VEC_BASE + i (modulo 2^ADDR_W).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- pc_actual  in  ADDR_W  address of the instruction in the current cycle.
- is_call  in  1  decoder: call instruction.
- is_ret  in  1  decoder: ret instruction.
- is_reti  in  1  decoder: return-from-interrupt instruction.
- is_ei  in  1  decoder: enable interrupts.
- is_di  in  1  decoder: disable interrupts.
- call_dest  in  ADDR_W  call target.
- irq  in  NUM_IRQ  level request lines, already synchronised.
- pila_out  in  ADDR_W  stack return address (combinational).
- pila_underflow  in  1  stack flag.
- pila_overflow  in  1  stack flag.
- push  out  1  to stack.
- pop  out  1  to stack.
- interrupt  out  1  to stack: selects the unmodified address on reti.
- pila_pc  out  ADDR_W  to stack pc_addr.
- pc_sel  out  2  next-PC mux: 00 = pc+1, 01 = call_dest, 10 = pc_dest (return), 11 = pc_dest (vector).
- pc_dest  out  ADDR_W  return address or vector.
- irq_ack  out  NUM_IRQ  one-hot, 1-cycle acknowledge.
- ie  out  1  interrupt-enable flag.
- halt  out  1  sticky fault; the CPU stops fetching.
- err_code  out  2  fault cause: 01 overflow, 10 underflow, 11 stack flag.

Behaviour:
- Reset (reset = 0, async): FSM = RUN, depth = 0, pending = 0, ie = 0, halt = 0, err_code = 00. All strobes and pc_sel are 0; pila_pc and pc_dest are 0.
- Pending latch: pending[i] sets on a rising edge of irq[i], meaning irq[i] = 1 and the previous-cycle sample = 0. It clears only in the cycle irq_ack[i] is asserted. A set and a clear of the same bit in one cycle resolve to set if a new edge arrives.
- Priority: lowest index wins.
- States: RUN (main code), ISR (in handler, no nesting), FALLO (halted).
- Take condition: `take_irq = ie & (pending != 0) & (state == RUN) & (depth < DEPTH)`.
- All strobe outputs are combinational from the current state and inputs, and valid in the same cycle. At most one stack operation occurs per cycle. The priority order within a cycle is:
  1. FALLO: all strobes 0, pc_sel 00, halt = 1. Exit only via reset.
  2. take_irq: the current instruction is squashed (its strobes are ignored).
     - push = 1, pila_pc = pc_actual, pc_sel = 11, pc_dest = VEC_BASE + i, irq_ack[i] = 1.
     - Next cycle: ie = 0, state = ISR, depth + 1.
  3. is_call:
     - If depth == DEPTH: no push; state = FALLO, err_code = 01.
     - Else: push = 1, pila_pc = pc_actual, pc_sel = 01, depth + 1.
  4. is_ret:
     - If depth == 0: no pop; state = FALLO, err_code = 10.
     - Else: pop = 1, interrupt = 0, pc_sel = 10, pc_dest = pila_out (the stack returns top + 1), depth − 1.
  5. is_reti:
     - Legal only in ISR with depth > 0; otherwise state = FALLO, err_code = 10.
     - If legal: pop = 1, interrupt = 1, pc_sel = 10, pc_dest = pila_out (the interrupted address, re-executed). Next cycle: ie = 1, state = RUN, depth − 1.
  6. is_ei: ie = 1 next cycle. is_di: ie = 0 next cycle. If both are asserted, di wins.
- Depth constraints: within ISR, call/ret nest normally. take_irq is false when depth == DEPTH; the request stays pending.
- reti and interrupts: a pending IRQ cannot be taken in the reti cycle. The earliest take is the cycle after reti.
- Stack flag cross-check: pila_overflow or pila_underflow = 1 in any RUN or ISR cycle → state = FALLO, err_code = 11 next cycle. This indicates desync with the stack.
- Widths: depth is $clog2(DEPTH+1) bits. Vector addition wraps modulo 2^ADDR_W.
- Reset mid-transaction: async reset aborts any strobe immediately, because the outputs decode from reset state. The stack is expected to be reset by the same signal.

Test Plan:
- call at pc 0x010 (call_dest 0x080), then ret with pila_out = 0x011 → push = 1 with pila_pc = 0x010, pc_sel = 01; then pop = 1, interrupt = 0, pc_sel = 10, pc_dest = 0x011, depth back to 0.
- ei, then irq[2] pulses at pc 0x020 → next cycle: push = 1, pila_pc = 0x020, pc_dest = 0x3F2, irq_ack = 0100, ie = 0. Then reti with pila_out = 0x020 → pop = 1, interrupt = 1, pc_dest = 0x020, ie = 1.
- irq[1] and irq[3] rising together with ie = 1 → irq[1] acked first. After reti and one cycle, irq[3] acked, vector 0x3F3.
- 16 nested calls, then a 17th call → no push on the 17th, halt = 1, err_code = 01. Further inputs are ignored until reset = 0.
- ret with depth = 0 after reset → pop = 0, halt = 1, err_code = 10. reti in RUN → same.
- reset asserted low during a call cycle → push drops immediately. After release: depth = 0, ie = 0, pending = 0, halt = 0.
